// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: access-width encoding, byte-lane masks
// and the alignment rule.
package mem_stage_pkg;

    // Access width codes, shared with the control unit and EX/MEM register.
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam int unsigned NB_LANES = 4;

    // Byte-lane masks before shifting to the addressed lane.
    localparam logic [NB_LANES-1:0] LANE_MASK_BYTE = 4'b0001;
    localparam logic [NB_LANES-1:0] LANE_MASK_HALF = 4'b0011;
    localparam logic [NB_LANES-1:0] LANE_MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10
    } access_e;

    // Width code 2'b11 is treated as a word access.
    function automatic access_e decode_width(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: decode_width = ACC_BYTE;
            WIDTH_HALF: decode_width = ACC_HALF;
            default:    decode_width = ACC_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] lane);
        case (decode_width(width))
            ACC_BYTE: is_misaligned = 1'b0;
            ACC_HALF: is_misaligned = lane[0];
            default:  is_misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-lane data memory: synchronous byte-enabled write with full clear on
// reset, and two combinational word read ports (access and debug).
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic [NB_LANES-1:0] i_byte_en,
    input  logic [NB_ADDR-1:0]  i_addr,
    input  logic [NB_DATA-1:0]  i_wdata,
    output logic [NB_DATA-1:0]  o_rdata,
    input  logic [NB_ADDR-1:0]  i_debug_addr,
    output logic [NB_DATA-1:0]  o_debug_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    // Reset takes priority, so a store presented with reset is dropped.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else begin
            for (int l = 0; l < NB_LANES; l++) begin
                if (i_byte_en[l]) begin
                    r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

    assign o_rdata      = r_mem[i_addr];
    assign o_debug_data = r_mem[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: alignment check, store lane generation, load extract and
// extend, and the MEM/WB pipeline register around a byte-addressable memory.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_mem2reg,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [4:0]         i_write_reg,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_ADDR-1:0] i_debug_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_read_data,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_debug_data
);

    logic [NB_ADDR-1:0]  w_word_idx;
    logic [1:0]          w_lane;
    access_e             w_access;
    logic                w_misaligned;
    logic                w_store;
    logic [NB_LANES-1:0] w_byte_en;
    logic [NB_DATA-1:0]  w_store_data;
    logic [NB_DATA-1:0]  w_mem_word;
    logic [7:0]          w_load_byte;
    logic [15:0]         w_load_half;
    logic [NB_DATA-1:0]  w_load_data;
    logic                w_unused;

    logic                r_mem2reg;
    logic                r_regWrite;
    logic [4:0]          r_write_reg;
    logic [NB_DATA-1:0]  r_result;
    logic [NB_DATA-1:0]  r_read_data;
    logic                r_misaligned;

    // Address bits above the memory size are ignored, so accesses wrap.
    assign w_word_idx = i_result[NB_ADDR+1:2];
    assign w_lane     = i_result[1:0];
    assign w_unused   = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign w_access     = decode_width(i_width);
    assign w_misaligned = (i_mem2reg || i_memWrite) && is_misaligned(i_width, w_lane);
    assign w_store      = i_step && i_memWrite && !w_misaligned;

    // Store data is replicated across lanes; the byte enable picks the target.
    always_comb begin
        w_byte_en    = '0;
        w_store_data = i_data4Mem;
        case (w_access)
            ACC_BYTE: begin
                w_byte_en    = LANE_MASK_BYTE << w_lane;
                w_store_data = {4{i_data4Mem[7:0]}};
            end
            ACC_HALF: begin
                w_byte_en    = LANE_MASK_HALF << w_lane;
                w_store_data = {2{i_data4Mem[15:0]}};
            end
            default: begin
                w_byte_en    = LANE_MASK_WORD;
                w_store_data = i_data4Mem;
            end
        endcase
        if (!w_store) begin
            w_byte_en = '0;
        end
    end

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_byte_en    (w_byte_en),
        .i_addr       (w_word_idx),
        .i_wdata      (w_store_data),
        .o_rdata      (w_mem_word),
        .i_debug_addr (i_debug_addr),
        .o_debug_data (o_debug_data)
    );

    always_comb begin
        case (w_lane)
            2'd0:    w_load_byte = w_mem_word[7:0];
            2'd1:    w_load_byte = w_mem_word[15:8];
            2'd2:    w_load_byte = w_mem_word[23:16];
            default: w_load_byte = w_mem_word[31:24];
        endcase
        w_load_half = w_lane[1] ? w_mem_word[31:16] : w_mem_word[15:0];
    end

    // Loads read the pre-store word, so a simultaneous store is not visible.
    always_comb begin
        w_load_data = '0;
        if (i_mem2reg && !w_misaligned) begin
            case (w_access)
                ACC_BYTE: w_load_data = {{(NB_DATA-8){i_sign_flag & w_load_byte[7]}}, w_load_byte};
                ACC_HALF: w_load_data = {{(NB_DATA-16){i_sign_flag & w_load_half[15]}}, w_load_half};
                default:  w_load_data = w_mem_word;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_mem2reg    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_write_reg  <= '0;
            r_result     <= '0;
            r_read_data  <= '0;
            r_misaligned <= 1'b0;
        end else if (i_step) begin
            r_mem2reg    <= i_mem2reg;
            r_regWrite   <= i_regWrite && !(i_mem2reg && w_misaligned);
            r_write_reg  <= i_write_reg;
            r_result     <= i_result;
            r_read_data  <= w_load_data;
            r_misaligned <= w_misaligned;
        end
    end

    assign o_mem2reg    = r_mem2reg;
    assign o_regWrite   = r_regWrite;
    assign o_write_reg  = r_write_reg;
    assign o_result     = r_result;
    assign o_read_data  = r_read_data;
    assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// against a byte-array reference model of the memory and MEM/WB register.
module tb_mem_stage;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;
  localparam int MEM_BYTES = 4 * (2 ** NB_ADDR);

  logic               clk;
  logic               i_reset;
  logic               i_step;
  logic               i_mem2reg;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_width;
  logic               i_sign_flag;
  logic [4:0]         i_write_reg;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data4Mem;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_mem2reg;
  logic               o_regWrite;
  logic [4:0]         o_write_reg;
  logic [NB_DATA-1:0] o_result;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_debug_data;

  mem_stage #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_step       (i_step),
    .i_mem2reg    (i_mem2reg),
    .i_memWrite   (i_memWrite),
    .i_regWrite   (i_regWrite),
    .i_width      (i_width),
    .i_sign_flag  (i_sign_flag),
    .i_write_reg  (i_write_reg),
    .i_result     (i_result),
    .i_data4Mem   (i_data4Mem),
    .i_debug_addr (i_debug_addr),
    .o_mem2reg    (o_mem2reg),
    .o_regWrite   (o_regWrite),
    .o_write_reg  (o_write_reg),
    .o_result     (o_result),
    .o_read_data  (o_read_data),
    .o_misaligned (o_misaligned),
    .o_debug_data (o_debug_data)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  mem_m [MEM_BYTES];
  logic        e_mem2reg;
  logic        e_regWrite;
  logic [4:0]  e_write_reg;
  logic [31:0] e_result;
  logic [31:0] e_read_data;
  logic        e_mis;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    int b;
    b = (idx % (2 ** NB_ADDR)) * 4;
    return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".mem2reg"},   {31'd0, o_mem2reg},    {31'd0, e_mem2reg});
    check({tag, ".regWrite"},  {31'd0, o_regWrite},   {31'd0, e_regWrite});
    check({tag, ".write_reg"}, {27'd0, o_write_reg},  {27'd0, e_write_reg});
    check({tag, ".result"},    o_result,              e_result);
    check({tag, ".read_data"}, o_read_data,           e_read_data);
    check({tag, ".misaligned"},{31'd0, o_misaligned}, {31'd0, e_mis});
  endtask

  // One EX/MEM transaction: drive at negedge, latch at posedge, check after.
  task automatic do_op(input string tag, input bit step, input bit m2r, input bit mw,
                       input bit rw, input logic [1:0] w, input bit sg,
                       input logic [4:0] wr, input logic [31:0] res,
                       input logic [31:0] data);
    int a;
    int wsz;
    bit mis;
    logic [31:0] ld;
    @(negedge clk);
    i_step = step; i_mem2reg = m2r; i_memWrite = mw; i_regWrite = rw;
    i_width = w; i_sign_flag = sg; i_write_reg = wr; i_result = res; i_data4Mem = data;
    i_debug_addr = res[NB_ADDR+1:2];
    #1;
    check({tag, ".dbg_pre"}, o_debug_data, model_word(int'(res[NB_ADDR+1:2])));
    a   = int'(res % MEM_BYTES);
    wsz = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    mis = (m2r || mw) && (a % wsz != 0);
    ld  = 32'd0;
    if (m2r && !mis) begin
      if (wsz == 1) begin
        ld = 32'(mem_m[a]);
        if (sg && ld >= 128) ld = ld - 32'd256;
      end else if (wsz == 2) begin
        ld = 32'(mem_m[a]) + 32'(mem_m[a+1]) * 256;
        if (sg && ld >= 32768) ld = ld - 32'd65536;
      end else begin
        ld = model_word(a / 4);
      end
    end
    if (step) begin
      e_mem2reg = m2r; e_regWrite = rw && !(m2r && mis); e_write_reg = wr;
      e_result = res; e_read_data = ld; e_mis = mis;
      if (mw && !mis) begin
        for (int k = 0; k < wsz; k++) mem_m[a+k] = data[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    check({tag, ".dbg_post"}, o_debug_data, model_word(int'(res[NB_ADDR+1:2])));
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    i_reset = 1'b1; i_step = 1'b1; i_memWrite = 1'b1; i_mem2reg = 1'b0;
    i_regWrite = 1'b1; i_width = 2'b10; i_result = 32'h40; i_data4Mem = 32'hCAFEF00D;
    i_write_reg = 5'd9;
    @(posedge clk);
    #1;
    for (int k = 0; k < MEM_BYTES; k++) mem_m[k] = 8'h00;
    e_mem2reg = 0; e_regWrite = 0; e_write_reg = 0; e_result = 0; e_read_data = 0; e_mis = 0;
    check_outputs(tag);
    @(negedge clk);
    i_reset = 1'b0; i_step = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
    for (int k = 0; k < 2 ** NB_ADDR; k++) begin
      i_debug_addr = NB_ADDR'(k);
      #1;
      check({tag, ".dbg_clear"}, o_debug_data, 32'd0);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_step = 1'b0; i_mem2reg = 1'b0; i_memWrite = 1'b0; i_regWrite = 1'b0;
    i_width = 2'b00; i_sign_flag = 1'b0; i_write_reg = '0; i_result = '0; i_data4Mem = '0;
    i_debug_addr = '0;
    repeat (2) @(posedge clk);
    apply_reset("reset0");

    // word store/load
    do_op("st_word",  1, 0, 1, 0, 2'b10, 0, 5'd0, 32'h10, 32'hDEADBEEF);
    do_op("ld_word",  1, 1, 0, 1, 2'b10, 0, 5'd3, 32'h10, 32'h0);
    // byte stores then mixed loads
    do_op("st_b0",    1, 0, 1, 0, 2'b00, 0, 5'd0, 32'h20, 32'h11);
    do_op("st_b1",    1, 0, 1, 0, 2'b00, 0, 5'd0, 32'h21, 32'h22);
    do_op("st_b2",    1, 0, 1, 0, 2'b00, 0, 5'd0, 32'h22, 32'h33);
    do_op("st_b3",    1, 0, 1, 0, 2'b00, 0, 5'd0, 32'h23, 32'h80);
    do_op("ld_w20",   1, 1, 0, 1, 2'b10, 0, 5'd4, 32'h20, 32'h0);
    do_op("ld_bs23",  1, 1, 0, 1, 2'b00, 1, 5'd5, 32'h23, 32'h0);
    do_op("ld_bu23",  1, 1, 0, 1, 2'b00, 0, 5'd5, 32'h23, 32'h0);
    do_op("ld_hs22",  1, 1, 0, 1, 2'b01, 1, 5'd6, 32'h22, 32'h0);
    do_op("ld_w11",   1, 1, 0, 1, 2'b11, 0, 5'd6, 32'h20, 32'h0);
    // misaligned
    do_op("st_h21",   1, 0, 1, 0, 2'b01, 0, 5'd0, 32'h21, 32'hAAAA);
    do_op("ld_w22",   1, 1, 0, 1, 2'b10, 0, 5'd8, 32'h22, 32'h0);
    // step gating
    do_op("hold_st",  0, 0, 1, 1, 2'b10, 0, 5'd12, 32'h30, 32'h12345678);
    do_op("hold_st2", 0, 1, 1, 1, 2'b00, 1, 5'd13, 32'h30, 32'h87654321);
    do_op("step_st",  1, 0, 1, 0, 2'b10, 0, 5'd12, 32'h30, 32'h12345678);
    // illegal load+store: load sees pre-store data
    do_op("ldst",     1, 1, 1, 1, 2'b10, 0, 5'd14, 32'h30, 32'h0BADF00D);
    // wrap and passthrough
    do_op("st_wrap",  1, 0, 1, 0, 2'b10, 0, 5'd0, 32'h400, 32'h5A5AA5A5);
    do_op("ld_idx0",  1, 1, 0, 1, 2'b10, 0, 5'd1, 32'h0, 32'h0);
    do_op("pass",     1, 0, 0, 1, 2'b10, 0, 5'd7, 32'h1234, 32'h0);

    apply_reset("reset_mid");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 127));
      do_op("rand", $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), addr, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
